// File: rtl/ddr_cmd_pkg.sv
// Shared definitions for the DDR command sequencer.
//   CMD_READ / CMD_WRITE : the only legal arbiter command codes
//   state_t              : sequencer FSM states
//   cmd_legal()          : true for a code the sequencer will act on
package ddr_cmd_pkg;

  localparam logic [3:0] CMD_READ  = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;

  typedef enum logic [2:0] {INIT, IDLE, WAIT_RD, ISSUE, WDATA} state_t;

  function automatic logic cmd_legal(input logic [3:0] c);
    return (c == CMD_READ) || (c == CMD_WRITE);
  endfunction

endpackage

// File: rtl/ddr_beat_pack.sv
// Read-return assembler: packs two MEM_DW beats into one DATA_W word.
//   clk, rst_n  : clock, async active-low reset
//   beat_valid  : read beat strobe from the memory IP
//   beat_data   : read beat; first beat is the low half
//   word        : assembled word, held until the next completed read
//   word_valid  : one-cycle pulse the cycle after the second beat
//   done        : combinational, high on the cycle the second beat arrives
module ddr_beat_pack #(
  parameter int MEM_DW = 128,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat_valid,
  input  logic [MEM_DW-1:0] beat_data,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic              done
);

  logic              half;
  logic [MEM_DW-1:0] low;

  assign done = beat_valid & half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half       <= 1'b0;
      low        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= done;
      if (beat_valid) begin
        if (!half) begin
          low  <= beat_data;
          half <= 1'b1;
        end else begin
          word <= {beat_data, low};
          half <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// Arbiter-to-DDR3-IP command sequencer. Runs memory init, accepts one command
// per cmd_valid, issues it to the IP, splits writes into two beats and returns
// packed reads in order.
//   clk_133M, rst_n_133M            : clock, async active-low reset
//   cmd/cmd_valid/ddr_address/ddr_wr_data/cmd_busy : arbiter command side
//   ddr_rd_data/ddr_data_valid      : arbiter read-return side
//   init_done, cmd_err              : status (cmd_err is sticky)
//   init_start/mem_init_done        : IP init handshake
//   mem_cmd/mem_cmd_valid/mem_cmd_rdy/mem_addr/mem_burst_cnt : IP command
//   mem_datain_rdy/mem_write_data/mem_data_mask               : IP write beats
//   mem_read_data/mem_rd_valid                                : IP read beats
module ddr_cmd_sequencer
  import ddr_cmd_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 256,
  parameter int MEM_DW = 128,
  parameter int MAX_RD = 4
) (
  input  logic                clk_133M,
  input  logic                rst_n_133M,
  input  logic [3:0]          cmd,
  input  logic                cmd_valid,
  input  logic [ADDR_W-1:0]   ddr_address,
  input  logic [DATA_W-1:0]   ddr_wr_data,
  output logic                cmd_busy,
  output logic [DATA_W-1:0]   ddr_rd_data,
  output logic                ddr_data_valid,
  output logic                init_done,
  output logic                cmd_err,
  output logic                init_start,
  input  logic                mem_init_done,
  output logic [3:0]          mem_cmd,
  output logic                mem_cmd_valid,
  input  logic                mem_cmd_rdy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [4:0]          mem_burst_cnt,
  input  logic                mem_datain_rdy,
  output logic [MEM_DW-1:0]   mem_write_data,
  output logic [MEM_DW/8-1:0] mem_data_mask,
  input  logic [MEM_DW-1:0]   mem_read_data,
  input  logic                mem_rd_valid
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_RD);

  state_t              state;
  logic [3:0]          cnt;       // reads issued to the IP, not yet returned
  logic [3:0]          lat_cmd;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic                wbeat;     // 0: low half next, 1: high half next
  logic                rd_issue;
  logic                rd_done;

  // Decoded from registers only, so it is already high the cycle after an
  // accepted command and has no path from any input.
  assign cmd_busy       = !(state == IDLE && init_done && cnt < MAX_CNT);
  assign mem_cmd_valid  = (state == ISSUE);
  assign mem_cmd        = lat_cmd;
  assign mem_addr       = lat_addr;
  assign mem_write_data = wbeat ? lat_data[DATA_W-1:MEM_DW] : lat_data[MEM_DW-1:0];
  assign mem_burst_cnt  = 5'd1;
  assign mem_data_mask  = '0;

  assign rd_issue = mem_cmd_valid && mem_cmd_rdy && (lat_cmd == CMD_READ);

  // Issue and return in the same cycle cancel out.
  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      cnt <= '0;
    end else begin
      case ({rd_issue, rd_done})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      state      <= INIT;
      init_start <= 1'b0;
      init_done  <= 1'b0;
      cmd_err    <= 1'b0;
      lat_cmd    <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      wbeat      <= 1'b0;
    end else begin
      if (cmd_valid && (cmd_busy || !cmd_legal(cmd)))
        cmd_err <= 1'b1;
      case (state)
        INIT: begin
          init_start <= !mem_init_done;
          if (mem_init_done) begin
            init_done <= 1'b1;
            state     <= IDLE;
          end
        end
        IDLE: begin
          if (cmd_valid && !cmd_busy && cmd_legal(cmd)) begin
            lat_cmd  <= cmd;
            lat_addr <= ddr_address;
            lat_data <= ddr_wr_data;
            wbeat    <= 1'b0;
            // Read window full: park until a return frees a slot.
            if (cmd == CMD_READ && cnt >= MAX_CNT) state <= WAIT_RD;
            else                                   state <= ISSUE;
          end
        end
        WAIT_RD: if (cnt < MAX_CNT) state <= ISSUE;
        ISSUE: begin
          if (mem_cmd_rdy) state <= (lat_cmd == CMD_WRITE) ? WDATA : IDLE;
        end
        WDATA: begin
          if (mem_datain_rdy) begin
            wbeat <= !wbeat;
            if (wbeat) state <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  ddr_beat_pack #(
    .MEM_DW (MEM_DW),
    .DATA_W (DATA_W)
  ) u_pack (
    .clk        (clk_133M),
    .rst_n      (rst_n_133M),
    .beat_valid (mem_rd_valid),
    .beat_data  (mem_read_data),
    .word       (ddr_rd_data),
    .word_valid (ddr_data_valid),
    .done       (rd_done)
  );

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Self-checking bench for ddr_cmd_sequencer: the bench plays both the arbiter
// and the DDR IP, keeps a transaction-level model of what the sequencer must
// show, and compares every cycle; directed sections pin the model with literals.
module tb_ddr_cmd_sequencer;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 256;
  localparam int MEM_DW = 128;
  localparam int MAX_RD = 4;
  localparam logic [3:0] RD = 4'b0011;
  localparam logic [3:0] WR = 4'b0100;
  localparam logic [127:0] P5 = {32{4'h5}};
  localparam logic [127:0] PA = {32{4'hA}};
  localparam logic [127:0] P1 = {16{8'h11}};
  localparam logic [127:0] P2 = {16{8'h22}};

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [3:0]          cmd = '0;
  logic                cmd_valid = 1'b0;
  logic [ADDR_W-1:0]   ddr_address = '0;
  logic [DATA_W-1:0]   ddr_wr_data = '0;
  logic                cmd_busy;
  logic [DATA_W-1:0]   ddr_rd_data;
  logic                ddr_data_valid;
  logic                init_done;
  logic                cmd_err;
  logic                init_start;
  logic                mem_init_done = 1'b0;
  logic [3:0]          mem_cmd;
  logic                mem_cmd_valid;
  logic                mem_cmd_rdy = 1'b0;
  logic [ADDR_W-1:0]   mem_addr;
  logic [4:0]          mem_burst_cnt;
  logic                mem_datain_rdy = 1'b0;
  logic [MEM_DW-1:0]   mem_write_data;
  logic [MEM_DW/8-1:0] mem_data_mask;
  logic [MEM_DW-1:0]   mem_read_data = '0;
  logic                mem_rd_valid = 1'b0;

  always #5 clk = ~clk;

  ddr_cmd_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DW(MEM_DW), .MAX_RD(MAX_RD)
  ) dut (
    .clk_133M       (clk),
    .rst_n_133M     (rst_n),
    .cmd            (cmd),
    .cmd_valid      (cmd_valid),
    .ddr_address    (ddr_address),
    .ddr_wr_data    (ddr_wr_data),
    .cmd_busy       (cmd_busy),
    .ddr_rd_data    (ddr_rd_data),
    .ddr_data_valid (ddr_data_valid),
    .init_done      (init_done),
    .cmd_err        (cmd_err),
    .init_start     (init_start),
    .mem_init_done  (mem_init_done),
    .mem_cmd        (mem_cmd),
    .mem_cmd_valid  (mem_cmd_valid),
    .mem_cmd_rdy    (mem_cmd_rdy),
    .mem_addr       (mem_addr),
    .mem_burst_cnt  (mem_burst_cnt),
    .mem_datain_rdy (mem_datain_rdy),
    .mem_write_data (mem_write_data),
    .mem_data_mask  (mem_data_mask),
    .mem_read_data  (mem_read_data),
    .mem_rd_valid   (mem_rd_valid)
  );

  int checks = 0;
  int errors = 0;

  // stimulus knobs
  bit                d_rst = 1'b0, d_init = 1'b0, d_valid = 1'b0, hold_rd = 1'b0;
  logic [3:0]        d_cmd = '0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_data = '0;
  int unsigned       rdy_pct = 100, din_pct = 100, ret_pct = 100;
  logic [127:0]      beat_q[$];

  // observations of the DUT used by directed literal checks
  logic [127:0]      wseen[$];
  int                hs_reads = 0, hs_all = 0;
  logic [3:0]        hs_cmd = '0;
  logic [ADDR_W-1:0] hs_addr = '0;

  // model: transaction view of the sequencer
  bit                m_init = 0, m_istart = 0, m_err = 0, m_half = 0, m_dvalid = 0;
  int                m_out = 0;    // reads accepted by the IP and not yet returned
  int                m_pend = 0;   // 0 nothing pending, 1 waiting for IP accept, 2 write data phase
  int                m_beats = 0;
  logic [3:0]        m_cmd = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0, m_rdata = '0;
  logic [127:0]      m_low = '0;

  function automatic bit m_busy();
    return !(m_init && m_pend == 0 && m_out < MAX_RD);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
  endtask

  task automatic check_outputs();
    chk("init_start", init_start, m_istart);
    chk("init_done", init_done, m_init);
    chk("cmd_busy", cmd_busy, m_busy());
    chk("cmd_err", cmd_err, m_err);
    chk("mem_cmd_valid", mem_cmd_valid, m_pend == 1);
    if (m_pend == 1) begin
      chk("mem_cmd", mem_cmd, m_cmd);
      chk("mem_addr", mem_addr, m_addr);
    end
    chk("ddr_data_valid", ddr_data_valid, m_dvalid);
    chk("ddr_rd_data", ddr_rd_data, m_rdata);
    chk("mem_burst_cnt", mem_burst_cnt, 5'd1);
    chk("mem_data_mask", mem_data_mask, 16'd0);
    if (!rst_n) begin
      chk("rst_mem_cmd", mem_cmd, 4'd0);
      chk("rst_mem_addr", mem_addr, 25'd0);
      chk("rst_mem_write_data", mem_write_data, 128'd0);
    end
  endtask

  // One clock: check the current cycle, drive this cycle's inputs, advance the model.
  task automatic cyc();
    bit busy_now;
    @(negedge clk);
    check_outputs();
    busy_now       = m_busy();
    rst_n          = d_rst;
    mem_init_done  = d_init;
    cmd_valid      = d_valid;
    cmd            = d_cmd;
    ddr_address    = d_addr;
    ddr_wr_data    = d_data;
    d_valid        = 1'b0;
    mem_cmd_rdy    = ($urandom_range(99) < rdy_pct);
    mem_datain_rdy = rst_n && (m_pend == 2) && ($urandom_range(99) < din_pct);
    mem_rd_valid   = rst_n && !hold_rd && (m_out > 0) && ($urandom_range(99) < ret_pct);
    if (mem_rd_valid && beat_q.size() > 0) mem_read_data = beat_q.pop_front();
    else                                   mem_read_data = rnd128();
    if (rst_n && mem_cmd_valid && mem_cmd_rdy) begin
      hs_all++;
      hs_cmd  = mem_cmd;
      hs_addr = mem_addr;
      if (mem_cmd == RD) hs_reads++;
    end
    if (mem_datain_rdy) begin
      wseen.push_back(mem_write_data);
      chk("mem_write_data", mem_write_data, (m_beats == 0) ? m_data[127:0] : m_data[255:128]);
    end

    if (!rst_n) begin
      m_init = 0; m_istart = 0; m_err = 0; m_half = 0; m_dvalid = 0;
      m_out = 0; m_pend = 0; m_beats = 0; m_rdata = '0;
    end else begin
      m_dvalid = 0;
      if (mem_rd_valid) begin
        if (!m_half) begin
          m_low  = mem_read_data;
          m_half = 1;
        end else begin
          m_rdata  = {mem_read_data, m_low};
          m_dvalid = 1;
          m_half   = 0;
          m_out--;
        end
      end
      if (m_pend == 1 && mem_cmd_rdy) begin
        if (m_cmd == RD) begin m_out++; m_pend = 0; end
        else begin m_pend = 2; m_beats = 0; end
      end else if (m_pend == 2 && mem_datain_rdy) begin
        m_beats++;
        if (m_beats == 2) m_pend = 0;
      end
      if (cmd_valid) begin
        if (busy_now || !(cmd == RD || cmd == WR)) m_err = 1;
        else begin
          m_pend = 1; m_cmd = cmd; m_addr = ddr_address; m_data = ddr_wr_data;
        end
      end
      if (!m_init) begin
        m_istart = !mem_init_done;
        if (mem_init_done) m_init = 1;
      end
    end
  endtask

  task automatic send(input logic [3:0] c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    for (int n = 0; n < 300 && m_busy(); n++) cyc();
    if (m_busy()) timeout("send_wait_not_busy");
    d_valid = 1'b1; d_cmd = c; d_addr = a; d_data = d;
    cyc();
  endtask

  task automatic wait_init();
    for (int n = 0; n < 100 && !m_init; n++) cyc();
    if (!m_init) timeout("wait_init");
  endtask

  initial begin
    int h0;
    int r;
    // reset cycles
    repeat (3) cyc();

    // 1: init handshake, mem_init_done at cycle 20
    d_rst = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      d_init = (c >= 20);
      cyc();
      if (c == 1 || c == 20) chk("t1_init_start_high", init_start, 1'b1);
      if (c == 20) chk("t1_init_done_early", init_done, 1'b0);
      if (c == 21) begin
        chk("t1_init_done", init_done, 1'b1);
        chk("t1_cmd_busy", cmd_busy, 1'b0);
        chk("t1_init_start_low", init_start, 1'b0);
      end
    end

    // 2: directed write
    wseen.delete();
    send(WR, 25'h0001234, {PA, P5});
    for (int n = 0; n < 50 && wseen.size() < 2; n++) cyc();
    if (wseen.size() < 2) timeout("t2_write_beats");
    else begin
      chk("t2_beat0", wseen[0], P5);
      chk("t2_beat1", wseen[1], PA);
      chk("t2_mem_cmd", hs_cmd, WR);
      chk("t2_mem_addr", hs_addr, 25'h0001234);
      chk("t2_busy_on_last_beat", cmd_busy, 1'b1);
      cyc();
      chk("t2_busy_after", cmd_busy, 1'b0);
    end

    // 3: directed read
    beat_q.push_back(P1);
    beat_q.push_back(P2);
    send(RD, 25'h0000777, '0);
    begin
      bit seen = 0;
      for (int n = 0; n < 50 && !seen; n++) begin
        cyc();
        seen = ddr_data_valid;
      end
      if (!seen) timeout("t3_read_return");
      else begin
        chk("t3_rd_data", ddr_rd_data, {P2, P1});
        cyc();
        chk("t3_valid_pulse", ddr_data_valid, 1'b0);
        chk("t3_rd_data_held", ddr_rd_data, {P2, P1});
      end
    end

    // 4: read window limit
    hold_rd = 1'b1;
    h0 = hs_reads;
    for (int i = 0; i < 4; i++) send(RD, ADDR_W'(i), '0);
    repeat (10) cyc();
    chk("t4_reads_issued", hs_reads - h0, 4);
    chk("t4_busy_full", cmd_busy, 1'b1);
    hold_rd = 1'b0;
    send(RD, 25'h0000005, '0);
    repeat (5) cyc();
    chk("t4_fifth_issued", hs_reads - h0, 5);
    for (int n = 0; n < 200 && m_out > 0; n++) cyc();
    if (m_out > 0) timeout("t4_drain");

    // 5: illegal code, then cmd_valid while busy
    h0 = hs_all;
    send(4'b0111, 25'h0000abc, '0);
    repeat (3) cyc();
    chk("t5_err_illegal", cmd_err, 1'b1);
    chk("t5_no_issue", hs_all - h0, 0);
    d_rst = 1'b0; d_init = 1'b0;
    cyc(); cyc();
    chk("t5_err_cleared", cmd_err, 1'b0);
    d_rst = 1'b1;
    cyc();
    d_valid = 1'b1; d_cmd = RD; d_addr = '0;
    cyc(); cyc();
    chk("t5_err_busy", cmd_err, 1'b1);
    chk("t5_busy_no_issue", hs_all - h0, 0);
    d_init = 1'b1;
    wait_init();

    // 6: reset after first write beat
    wseen.delete();
    send(WR, 25'h1555555, {rnd128(), rnd128()});
    for (int n = 0; n < 50 && wseen.size() < 1; n++) cyc();
    if (wseen.size() < 1) timeout("t6_first_beat");
    d_rst = 1'b0; d_init = 1'b0;
    cyc(); cyc();
    chk("t6_busy_reset", cmd_busy, 1'b1);
    chk("t6_init_done_reset", init_done, 1'b0);
    chk("t6_one_beat_only", wseen.size(), 1);
    d_rst = 1'b1;
    cyc(); cyc();
    chk("t6_init_start_again", init_start, 1'b1);
    d_init = 1'b1;
    wait_init();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        rdy_pct = $urandom_range(20, 100);
        din_pct = $urandom_range(20, 100);
        ret_pct = $urandom_range(20, 100);
        hold_rd = ($urandom_range(3) == 0);
      end
      if (!m_busy() && $urandom_range(2) == 0) begin
        r = $urandom_range(15);
        d_valid = 1'b1;
        d_cmd   = (r == 0) ? 4'b1111 : ((r < 8) ? RD : WR);
        d_addr  = ADDR_W'($urandom);
        d_data  = {rnd128(), rnd128()};
      end else if ($urandom_range(60) == 0) begin
        d_valid = 1'b1;
        d_cmd   = RD;
      end
      cyc();
    end
    hold_rd = 1'b0;
    for (int n = 0; n < 500 && (m_out > 0 || m_busy()); n++) cyc();
    if (m_out > 0 || m_busy()) timeout("final_drain");
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
